// File: rtl/dm_store_tracer.sv
// dm_store_tracer: snoops data-memory stores into an FWFT record FIFO,
// halts capture a programmable number of cycles after the halt instruction.
module dm_store_tracer #(
    parameter int                 PC_W         = 16,
    parameter int                 ADDR_W       = 16,
    parameter int                 DATA_W       = 16,
    parameter int                 DEPTH        = 16,
    parameter logic [DATA_W-1:0]  HALT_INSTR   = 16'hF000,
    parameter int                 DRAIN_CYCLES = 1,
    parameter int                 DROP_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         mem_instr,
    input  logic [PC_W-1:0]           id_pc,
    input  logic [ADDR_W-1:0]         dm_addr,
    input  logic [DATA_W-1:0]         dm_wdata,
    input  logic                      dm_we,
    input  logic                      dm_re,
    input  logic                      rd_en,
    output logic                      rd_valid,
    output logic [PC_W-1:0]           rd_pc,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [DROP_W-1:0]         dropped,
    output logic                      halted,
    output logic                      done
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        STOP  = 2'd2
    } state_t;

    state_t              state_q;
    logic [7:0]          drain_q;
    logic                halted_q;
    logic                done_q;
    logic                overflow_q;
    logic [DROP_W-1:0]   dropped_q;
    logic [PW-1:0]       wr_q, wr_d;
    logic [PW-1:0]       rd_q, rd_d;

    logic [PC_W-1:0]     pc_mem   [DEPTH];
    logic [ADDR_W-1:0]   addr_mem [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];

    logic empty, full, cap, pop, push, drop;

    // Occupancy flags and the push/pop/drop decision for this edge.
    always_comb begin
        empty = (wr_q == rd_q);
        full  = (wr_q[AW] != rd_q[AW]) &&
                (wr_q[AW-1:0] == rd_q[AW-1:0]);
        // rst gating keeps a write from landing while reset is held
        cap   = dm_we & ~dm_re & (state_q != STOP) & ~rst;
        pop   = rd_en & ~empty;
        push  = cap & (~full | pop);
        drop  = cap & full & ~pop;
        wr_d  = wr_q + PW'(push);
        rd_d  = rd_q + PW'(pop);
    end

    // Record storage; stale contents are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q[AW-1:0]]   <= id_pc;
            addr_mem[wr_q[AW-1:0]] <= dm_addr;
            data_mem[wr_q[AW-1:0]] <= dm_wdata;
        end
    end

    // FIFO pointers and overflow bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (drop) begin
                overflow_q <= 1'b1;
                if (dropped_q != '1)
                    dropped_q <= dropped_q + DROP_W'(1);
            end
        end
    end

    // Halt sequencing: RUN -> (DRAIN) -> STOP, with sticky halted/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= done_q | ((state_q == STOP) & empty);
            unique case (state_q)
                RUN: begin
                    if (mem_instr == HALT_INSTR) begin
                        halted_q <= 1'b1;
                        drain_q  <= DRAIN_INIT;
                        state_q  <= (DRAIN_INIT != 8'd0) ? DRAIN : STOP;
                    end
                end
                DRAIN: begin
                    if (drain_q <= 8'd1) begin
                        drain_q <= '0;
                        state_q <= STOP;
                    end else begin
                        drain_q <= drain_q - 8'd1;
                    end
                end
                STOP: ;
                default: state_q <= STOP;
            endcase
        end
    end

    assign rd_valid = ~empty;
    assign rd_pc    = empty ? '0 : pc_mem[rd_q[AW-1:0]];
    assign rd_addr  = empty ? '0 : addr_mem[rd_q[AW-1:0]];
    assign rd_data  = empty ? '0 : data_mem[rd_q[AW-1:0]];
    assign count    = wr_q - rd_q;
    assign overflow = overflow_q;
    assign dropped  = dropped_q;
    assign halted   = halted_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dm_store_tracer.sv
// tb_dm_store_tracer: scoreboard bench for dm_store_tracer
// (DEPTH=4, DRAIN_CYCLES=1).
module tb_dm_store_tracer;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] addr;
        logic [15:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_instr;
    logic [15:0] id_pc;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_we;
    logic        dm_re;
    logic        rd_en;
    logic        rd_valid;
    logic [15:0] rd_pc;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic [2:0]  count;
    logic        overflow;
    logic [7:0]  dropped;
    logic        halted;
    logic        done;

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t sb[$];

    dm_store_tracer #(
        .DEPTH(4),
        .DRAIN_CYCLES(1)
    ) dut (
        .clk(clk), .rst(rst), .mem_instr(mem_instr), .id_pc(id_pc),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
        .dm_re(dm_re), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_pc(rd_pc), .rd_addr(rd_addr), .rd_data(rd_data),
        .count(count), .overflow(overflow), .dropped(dropped),
        .halted(halted), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [15:0] pc, input logic [15:0] a,
                         input logic [15:0] d, input bit exp_cap);
        id_pc    = pc;
        dm_addr  = a;
        dm_wdata = d;
        dm_we    = 1'b1;
        step();
        dm_we = 1'b0;
        if (exp_cap) sb.push_back('{pc: pc, addr: a, data: d});
    endtask

    task automatic pop_chk(input string tag);
        rec_t r;
        if (sb.size() == 0) begin
            chk({tag, "_sb"}, 0, 1);
            return;
        end
        r = sb.pop_front();
        chk({tag, "_valid"}, rd_valid, 1);
        chk({tag, "_pc"}, rd_pc, r.pc);
        chk({tag, "_addr"}, rd_addr, r.addr);
        chk({tag, "_data"}, rd_data, r.data);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_instr = '0; id_pc = '0; dm_addr = '0;
        dm_wdata = '0; dm_we = 1'b0; dm_re = 1'b0; rd_en = 1'b0;
        step(); step();
        chk("rst_count", count, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", dropped, 0);
        chk("rst_halted", halted, 0);
        chk("rst_done", done, 0);
        chk("rst_pc", rd_pc, 0);
        rst = 1'b0;
        step();

        // three stores in order, then drain
        store(16'd2, 16'h0010, 16'd5, 1);
        store(16'd3, 16'h0011, 16'd7, 1);
        store(16'd4, 16'h0012, 16'd9, 1);
        chk("three_count", count, 3);
        pop_chk("three0");
        pop_chk("three1");
        pop_chk("three2");
        chk("three_empty_cnt", count, 0);
        chk("three_empty_v", rd_valid, 0);

        // six stores into a 4-deep FIFO
        for (int i = 0; i < 6; i++)
            store(16'(16'h100 + i), 16'(16'h200 + i), 16'(16'h300 + i), i < 4);
        chk("ovf_count", count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", dropped, 2);

        // full: simultaneous store and pop
        chk("sim_pc", rd_pc, sb[0].pc);
        id_pc = 16'h0AAA; dm_addr = 16'h0BBB; dm_wdata = 16'h0CCC;
        dm_we = 1'b1; rd_en = 1'b1;
        step();
        dm_we = 1'b0; rd_en = 1'b0;
        void'(sb.pop_front());
        sb.push_back('{pc: 16'h0AAA, addr: 16'h0BBB, data: 16'h0CCC});
        chk("sim_count", count, 4);
        chk("sim_drop", dropped, 2);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("drain%0d", i));
        chk("drain_count", count, 0);

        // read-modify pattern (we & re) is not captured
        dm_re = 1'b1;
        store(16'h1, 16'h2, 16'h3, 0);
        dm_re = 1'b0;
        chk("we_re_count", count, 0);
        // pop on empty ignored
        rd_en = 1'b1;
        #3 chk("uflow_mid_v", rd_valid, 0);
        step();
        rd_en = 1'b0;
        chk("uflow_count", count, 0);
        chk("uflow_v", rd_valid, 0);
        // empty with push and pop: push only
        rd_en = 1'b1;
        store(16'h44, 16'h45, 16'h46, 1);
        rd_en = 1'b0;
        chk("pp_empty_count", count, 1);
        pop_chk("pp_empty");

        // asynchronous reset while in DRAIN with two records
        store(16'h20, 16'h30, 16'h40, 1);
        mem_instr = 16'hF000;
        store(16'h21, 16'h31, 16'h41, 1);
        mem_instr = '0;
        chk("pre_rst_halted", halted, 1);
        chk("pre_rst_count", count, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_pc", rd_pc, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_halted", halted, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_drop", dropped, 0);
        chk("arst_done", done, 0);
        #2 rst = 1'b0;
        sb.delete();
        store(16'h22, 16'h32, 16'h42, 1);
        chk("post_rst_count", count, 1);
        pop_chk("post_rst");

        // halt with drain window of one cycle
        mem_instr = 16'hF000;
        store(16'h50, 16'h51, 16'h52, 1);
        mem_instr = '0;
        store(16'h60, 16'h61, 16'h62, 1);
        store(16'h70, 16'h71, 16'h72, 0);
        chk("halt_halted", halted, 1);
        chk("halt_count", count, 2);
        chk("halt_done0", done, 0);
        pop_chk("halt0");
        pop_chk("halt1");
        chk("halt_empty", rd_valid, 0);
        chk("done_lag", done, 0);
        step();
        chk("done_set", done, 1);
        mem_instr = 16'hF000;
        store(16'h80, 16'h81, 16'h82, 0);
        mem_instr = '0;
        chk("stop_count", count, 0);
        chk("stop_done", done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_store_tracer.md
Name: dm_store_tracer

Overview:
- Synthesizable, parametrised successor to the bench-side data-memory store monitor.
- Snoops the core's data-memory port and captures every qualifying store as a {pc, addr, data} record into an on-chip FIFO.
- Detects the halt instruction in the MEM stage, stops capturing after a programmable drain window, and signals completion.
- Sits beside the core (parallel to the data-memory interface); a host or bench drains records through a first-word-fall-through (FWFT) read port.

Parameters:
- PC_W, 16, width of captured PC
- ADDR_W, 16, data-memory address width
- DATA_W, 16, data-memory word and instruction width
- DEPTH, 16, FIFO entries; power of two, minimum 2
- HALT_INSTR, 16'hF000, instruction encoding that starts the halt sequence
- DRAIN_CYCLES, 1, cycles captures remain enabled after halt is seen; range 0..255
- DROP_W, 8, width of the saturating dropped-record counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_instr  in  DATA_W  instruction currently in MEM stage
- id_pc  in  PC_W  PC associated with the current store
- dm_addr  in  ADDR_W  data-memory address
- dm_wdata  in  DATA_W  data-memory write data
- dm_we  in  1  data-memory write enable
- dm_re  in  1  data-memory read enable
- rd_en  in  1  pop request from the drain side
- rd_valid  out  1  FIFO non-empty; head record is valid
- rd_pc  out  PC_W  head record PC
- rd_addr  out  ADDR_W  head record address
- rd_data  out  DATA_W  head record data
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; a capture was dropped because the FIFO was full
- dropped  out  DROP_W  number of dropped captures, saturating at all-ones
- halted  out  1  halt instruction has been seen
- done  out  1  capture stopped and FIFO empty

Behaviour:
- Reset (asynchronous): FIFO pointers 0; state RUN; count 0; rd_valid 0; overflow 0; dropped 0; halted 0; done 0; drain counter 0. rd_pc, rd_addr and rd_data read 0 while the FIFO is empty.
- Reset mid-operation: discards all stored records and returns to RUN immediately. No partial write may survive.
- Capture qualifier: cap = dm_we & ~dm_re & (state != STOP). Evaluated at the rising edge.
- When cap is true, {id_pc, dm_addr, dm_wdata} is written at the tail.
- Write-to-read latency: a record captured at edge N is visible on rd_* with rd_valid=1 after edge N. There is no bypass within the same cycle.
- FWFT read: rd_* always present the head record.
- Pop: rd_en & rd_valid advances the head at the edge. rd_en when empty is ignored; no underflow and no state change.
- Pointers: $clog2(DEPTH)+1 bits wide, wrapping modulo 2*DEPTH.
  - empty = pointers equal.
  - full = MSBs differ and the remaining bits are equal.
- Full with cap and no pop: record dropped; overflow set (sticky until reset); dropped increments and saturates.
- Full with cap and a valid pop in the same cycle: both happen; count unchanged; no drop.
- Empty with cap and rd_en in the same cycle: push only; the pop is ignored.
- count: +1 on push only, -1 on pop only, unchanged for both or neither.
- State machine:
  - RUN: capturing. If mem_instr == HALT_INSTR at an edge, halted<=1 and the drain counter is loaded with DRAIN_CYCLES. Next state is DRAIN if DRAIN_CYCLES>0, else STOP.
  - DRAIN: capturing. The counter decrements each edge; on reaching 1 -> STOP. A store in the final DRAIN cycle is still captured.
  - STOP: no captures. Draining via rd_en continues. Terminal until reset; halt instructions seen here are ignored.
- A store on the same edge the halt is detected is captured, because the state is still RUN at that edge.
- halted is sticky until reset.
- done = (state==STOP) & empty, registered; it may deassert only by reset.
- Widths: no arithmetic is performed on captured fields; they are stored verbatim.

Test Plan:
- Reset then three stores (pc=2/addr=0010/data=5, pc=3/0011/7, pc=4/0012/9), rd_en low -> count=3, rd_valid=1, head shows pc 2, 0010, 5. Three pops return the records in order, then count=0 and rd_valid=0.
- DEPTH=4; six stores with no pops -> count=4, overflow=1, dropped=2. Popping yields only the first four records.
- Full FIFO with a simultaneous store and pop -> count stays 4, dropped unchanged. The new record appears after the three older ones.
- dm_we=1 and dm_re=1 together -> no capture, count unchanged. rd_en on an empty FIFO -> count stays 0 with no glitch on rd_valid.
- DRAIN_CYCLES=1; mem_instr=F000 with a store on the same edge, then a store the next cycle, then a store the cycle after:
  - First two stores captured, third rejected.
  - halted=1.
  - done=1 one cycle after the last record is popped.
- Assert rst asynchronously (mid-cycle) while count=2 in DRAIN -> all outputs return to 0 immediately, state RUN. The next store is captured normally.
